// File: rtl/ram_avalon_wait.sv
// Word-addressed RAM test model, Avalon-MM slave with wait states and registered reads.
// Define RAM_AVALON_PROTOCOL_CHECK_EN for master-protocol checks and a per-transfer trace.
module ram_avalon_wait #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    ADDR_WIDTH    = 11,
  parameter int    WAIT_CYCLES   = 2,
  parameter string RAM_INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             address,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state;
  logic [3:0]            wait_cnt;
  logic                  busy;
  logic                  req;
  logic                  last;
  logic                  done;
  logic                  do_wr;
  logic                  do_rd;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  unused_ok;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign unused_ok = &{1'b0, address};
  assign idx       = address[ADDR_WIDTH+LSB-1:LSB];
  assign busy      = (state == BUSY);
  assign req       = read | write;
  assign last      = busy && (wait_cnt == 4'd0);

  assign waitrequest = (WAIT_CYCLES == 0) ? 1'b0 : (req & ~last);

  assign done  = ~reset & req & ((WAIT_CYCLES == 0) | last);
  assign do_wr = done & write;
  assign do_rd = done & read & ~write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= 4'd0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= do_rd;
      if (do_rd) readdata <= mem[idx];
      if (WAIT_CYCLES > 0) begin
        unique case (1'b1)
          !busy && req: begin
            state    <= BUSY;
            wait_cnt <= 4'(WAIT_CYCLES - 1);
          end
          busy && !req: begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
          end
          busy && req && (wait_cnt != 4'd0): begin
            wait_cnt <= wait_cnt - 4'd1;
          end
          busy && req && (wait_cnt == 4'd0): begin
            state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

`ifdef RAM_AVALON_PROTOCOL_CHECK_EN
  logic                    p_wait;
  logic [31:0]             p_addr;
  logic [DATA_WIDTH-1:0]   p_wd;
  logic [DATA_WIDTH/8-1:0] p_be;

  always @(posedge clk) begin
    if (!reset) begin
      if (read && write)
        $error("%0t ram_avalon_wait: read and write both high addr=%h", $time, address);
      if (p_wait && !req)
        $error("%0t ram_avalon_wait: request dropped under waitrequest addr=%h", $time, p_addr);
      else if (p_wait && (address != p_addr || writedata != p_wd || byteenable != p_be))
        $error("%0t ram_avalon_wait: inputs changed under waitrequest addr=%h", $time, address);
      if (do_wr)
        $display("%0t ram_avalon_wait: write addr=%h data=%h be=%h", $time, address, writedata, byteenable);
      if (do_rd)
        $display("%0t ram_avalon_wait: read addr=%h data=%h", $time, address, mem[idx]);
    end
    p_wait <= waitrequest & ~reset;
    p_addr <= address;
    p_wd   <= writedata;
    p_be   <= byteenable;
  end
`else
`endif

endmodule

// File: tb/tb_ram_avalon_wait.sv
// Directed bench for ram_avalon_wait: three instances with 2, 0 and 3 wait states.
module tb_ram_avalon_wait;

  logic        clk;
  logic        rst  [3];
  logic [31:0] addr [3];
  logic        rd   [3];
  logic        wr   [3];
  logic [3:0]  be   [3];
  logic [31:0] wd   [3];
  logic        wq   [3];
  logic [31:0] rdat [3];
  logic        rdv  [3];

  int total = 0;
  int bad   = 0;
  int w;

  ram_avalon_wait #(.WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(rst[0]), .address(addr[0]), .read(rd[0]),
    .write(wr[0]), .byteenable(be[0]), .writedata(wd[0]),
    .waitrequest(wq[0]), .readdata(rdat[0]), .readdatavalid(rdv[0])
  );

  ram_avalon_wait #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(rst[1]), .address(addr[1]), .read(rd[1]),
    .write(wr[1]), .byteenable(be[1]), .writedata(wd[1]),
    .waitrequest(wq[1]), .readdata(rdat[1]), .readdatavalid(rdv[1])
  );

  ram_avalon_wait #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(rst[2]), .address(addr[2]), .read(rd[2]),
    .write(wr[2]), .byteenable(be[2]), .writedata(wd[2]),
    .waitrequest(wq[2]), .readdata(rdat[2]), .readdatavalid(rdv[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one transfer, returns number of waitrequest-high cycles seen.
  task automatic xfer(input int s, input logic r, input logic wn,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int waits);
    addr[s] = a; wd[s] = d; be[s] = b; rd[s] = r; wr[s] = wn;
    waits = 0;
    #1;
    while (wq[s] && waits < 40) begin
      waits++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rd[s] = 1'b0; wr[s] = 1'b0;
  endtask

  task automatic rd_chk(input int s, input logic [31:0] a,
                        input int ew, input logic [31:0] exp,
                        input string tag);
    int n;
    xfer(s, 1'b1, 1'b0, a, 32'h0, 4'h0, n);
    check({tag, "_waits"}, 64'(n), 64'(ew));
    check({tag, "_rdv"}, 64'(rdv[s]), 64'd1);
    check({tag, "_data"}, 64'(rdat[s]), 64'(exp));
  endtask

  logic [31:0] vals [3];

  initial begin
    vals[0] = 32'hA1A1A1A1;
    vals[1] = 32'hB2B2B2B2;
    vals[2] = 32'hC3C3C3C3;
    for (int s = 0; s < 3; s++) begin
      rst[s] = 1'b1; rd[s] = 1'b0; wr[s] = 1'b0;
      addr[s] = '0; be[s] = '0; wd[s] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("rst_wq",   64'(wq[0]),   64'd0);
    check("rst_rdv",  64'(rdv[0]),  64'd0);
    check("rst_data", 64'(rdat[0]), 64'd0);
    for (int s = 0; s < 3; s++) rst[s] = 1'b0;
    @(posedge clk); #1;

    // two wait states, full write then read back
    xfer(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, w);
    check("wr10_waits", 64'(w), 64'd2);
    check("wr10_rdv", 64'(rdv[0]), 64'd0);
    rd_chk(0, 32'h10, 2, 32'hDEADBEEF, "rd10");
    @(posedge clk); #1;
    check("rd10_pulse_end", 64'(rdv[0]), 64'd0);
    check("rd10_hold", 64'(rdat[0]), 64'hDEADBEEF);

    // byte-enable merge
    xfer(0, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, w);
    xfer(0, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, w);
    rd_chk(0, 32'h20, 2, 32'h11BB33DD, "rd20");

    // aliasing: high bits wrap, low bits ignored
    xfer(0, 1'b0, 1'b1, 32'h0, 32'h5, 4'hF, w);
    rd_chk(0, 32'h2000, 2, 32'h5, "rd2000");
    rd_chk(0, 32'h3, 2, 32'h5, "rd3");

    // read and write together acts as a write
    xfer(0, 1'b1, 1'b1, 32'h50, 32'h12345678, 4'hF, w);
    check("rw50_rdv", 64'(rdv[0]), 64'd0);
    rd_chk(0, 32'h50, 2, 32'h12345678, "rd50");

    // zero byteenable is a no-op
    xfer(0, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, w);
    rd_chk(0, 32'h10, 2, 32'hDEADBEEF, "be0");

    // abandoned read: no pulse, next transfer pays full wait
    addr[0] = 32'h10; rd[0] = 1'b1;
    #1;
    check("abn_wq", 64'(wq[0]), 64'd1);
    @(posedge clk); #1;
    rd[0] = 1'b0;
    @(posedge clk); #1;
    check("abn_rdv", 64'(rdv[0]), 64'd0);
    rd_chk(0, 32'h10, 2, 32'hDEADBEEF, "abn_next");

    // zero wait states: back-to-back writes then reads
    for (int i = 0; i < 3; i++) begin
      addr[1] = 32'(4 * i); wd[1] = vals[i]; be[1] = 4'hF; wr[1] = 1'b1;
      #1;
      check("w0_wr_wq", 64'(wq[1]), 64'd0);
      @(posedge clk); #1;
    end
    wr[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr[1] = 32'(4 * i); rd[1] = 1'b1;
      #1;
      check("w0_rd_wq", 64'(wq[1]), 64'd0);
      @(posedge clk); #1;
      check("w0_rdv", 64'(rdv[1]), 64'd1);
      check("w0_data", 64'(rdat[1]), 64'(vals[i]));
    end
    rd[1] = 1'b0;
    @(posedge clk); #1;
    check("w0_rdv_end", 64'(rdv[1]), 64'd0);
    check("w0_hold", 64'(rdat[1]), 64'(vals[2]));

    // three wait states: reset one cycle into a write aborts it
    addr[2] = 32'h40; wd[2] = 32'hFFFFFFFF; be[2] = 4'hF; wr[2] = 1'b1;
    #1;
    check("w3_wq", 64'(wq[2]), 64'd1);
    @(posedge clk); #1;
    rst[2] = 1'b1; wr[2] = 1'b0;
    #1;
    check("w3_rst_wq", 64'(wq[2]), 64'd0);
    check("w3_rst_rdv", 64'(rdv[2]), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst[2] = 1'b0;
    @(posedge clk); #1;
    rd_chk(2, 32'h40, 3, 32'h0, "w3_rd40");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
